// File: rtl/fft_frame_sequencer.sv
`timescale 1ns/1ps
// fft_frame_sequencer
//   Bridges the audio codec read handshake to the FFT sink port. Stereo
//   pairs are popped from the codec and mixed to mono. Each sample is then
//   written into one half of a two-bank (ping-pong) frame buffer. Every full
//   bank is streamed to the FFT with sop/eop framing and sink_ready
//   back-pressure.
//
//   Optional build macro: SEQ_DCBLOCK_EN
//     When defined, a leaky DC-offset remover sits between the mono mix and
//     the buffer. When undefined, mono samples are stored unmodified.
//
// Ports
//   clock, reset        rising-edge clock; synchronous active-high reset
//   enable              1 = keep popping codec samples
//   codec_read_ready    codec has a sample pair available
//   codec_read          one-cycle pop strobe to the codec
//   readdata_left/right signed stereo sample pair
//   sink_ready          FFT accepts a beat
//   sink_valid/sop/eop  beat framing toward the FFT
//   sink_real           mono sample toward the FFT
//   sink_imag           constant zero
//   overrun             sticky: at least one sample was dropped
//   drop_count          dropped samples, saturating
//   frame_count         frames whose eop was accepted, wrapping
module fft_frame_sequencer #(
  parameter int DATA_W    = 24,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              codec_read_ready,
  output logic              codec_read,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic              overrun,
  output logic [15:0]       drop_count,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_SENDING} bank_t;
  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

  // Both banks share one RAM; the bank number is the address MSB.
  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  bank_t             bank_st [2];
  state_t            state;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_idx;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_idx;

  // ---------------------------------------------------------------------
  // Mono mix: one extra bit of headroom, so halving never overflows.
  // ---------------------------------------------------------------------
  logic signed [DATA_W:0] mix_sum;
  logic [DATA_W-1:0]      mono;
  logic [DATA_W-1:0]      y;

  always_comb begin
    mix_sum = $signed({readdata_left[DATA_W-1], readdata_left})
            + $signed({readdata_right[DATA_W-1], readdata_right});
    mono    = DATA_W'(mix_sum >>> 1);
  end

`ifdef SEQ_DCBLOCK_EN
  // acc converges to 256 * DC level; its upper bits are the offset estimate.
  logic signed [DATA_W+7:0] acc;
  logic signed [DATA_W:0]   dc_diff;

  always_comb begin
    dc_diff = $signed({mono[DATA_W-1], mono})
            - $signed({acc[DATA_W+7], acc[DATA_W+7:8]});
    if (dc_diff[DATA_W] != dc_diff[DATA_W-1])
      y = dc_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                          : {1'b0, {(DATA_W-1){1'b1}}};
    else
      y = dc_diff[DATA_W-1:0];
  end
`else
  always_comb y = mono;
`endif

  // ---------------------------------------------------------------------
  // Capture and stream control decode
  // ---------------------------------------------------------------------
  logic              take;
  logic              rd_last;
  logic              eop_xfer;
  logic              wr_ok;
  logic              store;
  logic              drop;
  logic              wr_last;
  logic              any_full;
  logic              sel_bank;
  logic              other_bank;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W:0]   rd_addr;

  always_comb begin
    take       = codec_read_ready & enable & ~codec_read;
    rd_last    = (rd_idx == LAST);
    eop_xfer   = (state == S_SEND) & sink_ready & rd_last;
    // A bank released by an eop on this same edge may take the sample.
    wr_ok      = (bank_st[wr_bank] == B_EMPTY)
               | (bank_st[wr_bank] == B_FILLING)
               | (eop_xfer & (rd_bank == wr_bank));
    store      = take & wr_ok;
    drop       = take & ~wr_ok;
    wr_last    = (wr_idx == LAST);
    any_full   = (bank_st[0] == B_FULL) | (bank_st[1] == B_FULL);
    sel_bank   = (bank_st[0] == B_FULL) ? 1'b0 : 1'b1;
    other_bank = ~rd_bank;
    rd_next    = rd_idx + 1'b1;

    // Address of the beat that the output register loads on this edge.
    if (state == S_IDLE)
      rd_addr = {sel_bank, {ADDR_W{1'b0}}};
    else if (rd_last)
      rd_addr = {other_bank, {ADDR_W{1'b0}}};
    else
      rd_addr = {rd_bank, rd_next};
  end

  assign sink_imag = '0;

  // ---------------------------------------------------------------------
  // Buffer write port
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (store)
      mem[{wr_bank, wr_idx}] <= y;
  end

  // ---------------------------------------------------------------------
  // Sequencer: codec pop, bank bookkeeping, stream FSM, status counters.
  // sink_real is the RAM read register. It reloads only when the next beat
  // is due, so data stays stable under back-pressure and streams 1 beat per
  // cycle otherwise.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      bank_st[0]  <= B_EMPTY;
      bank_st[1]  <= B_EMPTY;
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      rd_bank     <= 1'b0;
      rd_idx      <= '0;
      codec_read  <= 1'b0;
      sink_valid  <= 1'b0;
      sink_sop    <= 1'b0;
      sink_eop    <= 1'b0;
      sink_real   <= '0;
      overrun     <= 1'b0;
      drop_count  <= '0;
      frame_count <= '0;
`ifdef SEQ_DCBLOCK_EN
      acc         <= '0;
`endif
    end else begin
      codec_read <= take;

      unique case (state)
        S_IDLE: begin
          if (any_full) begin
            state             <= S_SEND;
            rd_bank           <= sel_bank;
            rd_idx            <= '0;
            bank_st[sel_bank] <= B_SENDING;
            sink_valid        <= 1'b1;
            sink_sop          <= 1'b1;
            sink_eop          <= 1'b0;
            sink_real         <= mem[rd_addr];
          end
        end
        S_SEND: begin
          if (sink_ready) begin
            if (rd_last) begin
              bank_st[rd_bank] <= B_EMPTY;
              frame_count      <= frame_count + 16'd1;
              if (bank_st[other_bank] == B_FULL) begin
                rd_bank             <= other_bank;
                rd_idx              <= '0;
                bank_st[other_bank] <= B_SENDING;
                sink_sop            <= 1'b1;
                sink_eop            <= 1'b0;
                sink_real           <= mem[rd_addr];
              end else begin
                state      <= S_IDLE;
                sink_valid <= 1'b0;
                sink_sop   <= 1'b0;
                sink_eop   <= 1'b0;
              end
            end else begin
              rd_idx    <= rd_next;
              sink_sop  <= 1'b0;
              sink_eop  <= (rd_next == LAST);
              sink_real <= mem[rd_addr];
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Capture updates come after the stream updates so that a bank freed
      // by eop on this edge ends up FILLING rather than EMPTY.
      // The write pointer always flips to the other bank after a frame
      // completes. Because banks are filled and drained alternately, the
      // other bank is then either EMPTY or the next one queued to drain.
      if (store) begin
        wr_idx <= wr_idx + 1'b1;  // wraps to 0 after LAST
        if (wr_last) begin
          bank_st[wr_bank] <= B_FULL;
          wr_bank          <= ~wr_bank;
        end else begin
          bank_st[wr_bank] <= B_FILLING;
        end
`ifdef SEQ_DCBLOCK_EN
        acc <= acc + $signed({{8{y[DATA_W-1]}}, y});
`endif
      end

      if (drop) begin
        overrun <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

  localparam int DW = 24;
  localparam int FL = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          codec_read_ready;
  logic          codec_read;
  logic [DW-1:0] readdata_left;
  logic [DW-1:0] readdata_right;
  logic          sink_ready;
  logic          sink_valid;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_real;
  logic [DW-1:0] sink_imag;
  logic          overrun;
  logic [15:0]   drop_count;
  logic [15:0]   frame_count;

  fft_frame_sequencer #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .codec_read_ready(codec_read_ready), .codec_read(codec_read),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .overrun(overrun), .drop_count(drop_count), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int pos = 0;
  int last_sop_cyc = -10;
  int last_eop_cyc = -10;
  int btb = 0;
  logic [DW-1:0] last_real = '0;
  logic [DW-1:0] exp_q[$];

`ifdef SEQ_DCBLOCK_EN
  logic signed [DW+7:0] m_acc = '0;
`endif

  // Reference: mono = (L + R) >>> 1, optionally followed by the DC remover.
  function automatic logic [DW-1:0] model_y(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic signed [DW:0] s;
    logic [DW-1:0] m;
`ifdef SEQ_DCBLOCK_EN
    logic signed [DW:0] d;
    logic [DW-1:0] yy;
`endif
    s = $signed({l[DW-1], l}) + $signed({r[DW-1], r});
    m = s[DW:1];
`ifdef SEQ_DCBLOCK_EN
    d = $signed({m[DW-1], m}) - $signed({m_acc[DW+7], m_acc[DW+7:8]});
    if (d > 25'sd8388607)       yy = 24'h7FFFFF;
    else if (d < -25'sd8388608) yy = 24'h800000;
    else                        yy = d[DW-1:0];
    m_acc = m_acc + $signed({{8{yy[DW-1]}}, yy});
    return yy;
`else
    return m;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pos = 0;
`ifdef SEQ_DCBLOCK_EN
    m_acc = '0;
`endif
  endtask

  // Scoreboard: every accepted beat is compared with the oldest expected sample.
  always @(negedge clock) begin : monitor
    logic [DW-1:0] e;
    cyc++;
    if (!reset && sink_valid && sink_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got=%h required=none", sink_real);
      end else begin
        e = exp_q.pop_front();
        if (sink_real !== e) begin
          errors++;
          $display("FAIL beat_data pos=%0d got=%h required=%h", pos, sink_real, e);
        end
      end
      checks++;
      if (sink_sop !== (pos == 0)) begin
        errors++;
        $display("FAIL beat_sop pos=%0d got=%b required=%b", pos, sink_sop, (pos == 0));
      end
      checks++;
      if (sink_eop !== (pos == FL-1)) begin
        errors++;
        $display("FAIL beat_eop pos=%0d got=%b required=%b", pos, sink_eop, (pos == FL-1));
      end
      checks++;
      if (sink_imag !== '0) begin
        errors++;
        $display("FAIL sink_imag got=%h required=0", sink_imag);
      end
      if (sink_sop && last_eop_cyc == cyc - 1) btb++;
      if (sink_sop) last_sop_cyc = cyc;
      if (sink_eop) last_eop_cyc = cyc;
      last_real = sink_real;
      beats++;
      pos = (pos + 1) % FL;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit store);
    bit done;
    done = 1'b0;
    if (store) exp_q.push_back(model_y(l, r));
    readdata_left    = l;
    readdata_right   = r;
    codec_read_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (codec_read) begin
        done = 1'b1;
        break;
      end
    end
    codec_read_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL codec_pop got=timeout required=codec_read pulse");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (exp_q.size() == 0 && !sink_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; codec_read_ready = 1'b0; sink_ready = 1'b0;
    readdata_left = '0; readdata_right = '0;
    tick(); tick();
    checks++;
    if ({codec_read, sink_valid, sink_sop, sink_eop, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required=00000",
               {codec_read, sink_valid, sink_sop, sink_eop, overrun});
    end
    checks++;
    if (sink_real !== '0 || sink_imag !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h required=0/0", sink_real, sink_imag);
    end
    checks++;
    if (drop_count !== 16'd0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts got=%0d/%0d required=0/0", drop_count, frame_count);
    end
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] fc0;
    fc0 = frame_count;
    enable = 1'b1; sink_ready = 1'b1;
    for (int k = 1; k <= FL; k++) push(DW'(k), DW'(k), 1'b1);
    drain();
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL basic_frame_count got=%0d required=%0d", frame_count, fc0 + 16'd1);
    end
    checks++;
    if (last_eop_cyc - last_sop_cyc != FL - 1) begin
      errors++;
      $display("FAIL basic_contiguous got=%0d required=%0d", last_eop_cyc - last_sop_cyc, FL - 1);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] fc0;
    fc0 = frame_count;
    sink_ready = 1'b1;
    push(24'h7FFFFF, 24'h7FFFFF, 1'b1);
    push(24'h800000, 24'h800000, 1'b1);
    push(24'hFFFFFD, 24'h000002, 1'b1);
    push(24'h000001, 24'h000000, 1'b1);
    for (int k = 0; k < 4; k++) push(DW'($urandom), DW'($urandom), 1'b1);
    drain();
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL extremes_frame_count got=%0d required=%0d", frame_count, fc0 + 16'd1);
    end
  endtask

  task automatic test_enable();
    logic [15:0] fc0;
    int pulses;
    fc0 = frame_count;
    pulses = 0;
    for (int k = 0; k < 4; k++) push(DW'(100 + k), DW'(200 + k), 1'b1);
    enable = 1'b0;
    readdata_left = DW'(300); readdata_right = DW'(400);
    codec_read_ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (codec_read) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL enable_off_pulses got=%0d required=0", pulses);
    end
    checks++;
    if (sink_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_partial_valid got=%b required=0", sink_valid);
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) push(DW'(300 + k), DW'(400 + k), 1'b1);
    drain();
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL enable_frame_count got=%0d required=%0d", frame_count, fc0 + 16'd1);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] fc0;
    int b0;
    bit pat[4];
    bit prev_stall;
    logic [DW+2:0] saved;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    fc0 = frame_count;
    b0 = beats;
    prev_stall = 1'b0;
    saved = '0;
    sink_ready = 1'b0;
    for (int k = 0; k < FL; k++) push(DW'($urandom), DW'($urandom), 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q.size() == 0 && !sink_valid) break;
      sink_ready = pat[i % 4];
      @(negedge clock);
      if (prev_stall) begin
        checks++;
        if ({sink_valid, sink_sop, sink_eop, sink_real} !== saved) begin
          errors++;
          $display("FAIL bp_hold got=%h required=%h",
                   {sink_valid, sink_sop, sink_eop, sink_real}, saved);
        end
      end
      saved = {sink_valid, sink_sop, sink_eop, sink_real};
      prev_stall = sink_valid & ~sink_ready;
    end
    sink_ready = 1'b1;
    drain();
    checks++;
    if (beats - b0 != FL) begin
      errors++;
      $display("FAIL bp_transfers got=%0d required=%0d", beats - b0, FL);
    end
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL bp_frame_count got=%0d required=%0d", frame_count, fc0 + 16'd1);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] fc0;
    int btb0;
    fc0 = frame_count;
    btb0 = btb;
    checks++;
    if (overrun !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL overrun_pre got=%b/%0d required=0/0", overrun, drop_count);
    end
    sink_ready = 1'b0;
    for (int k = 0; k < 2*FL; k++) push(DW'(1000 + k), DW'(1000 + k), 1'b1);
    push(DW'(5555), DW'(5555), 1'b0);
    tick();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got=%b required=1", overrun);
    end
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL overrun_drop_count got=%0d required=1", drop_count);
    end
    checks++;
    if (sink_valid !== 1'b1 || sink_sop !== 1'b1) begin
      errors++;
      $display("FAIL overrun_stalled_head got=%b%b required=11", sink_valid, sink_sop);
    end
    sink_ready = 1'b1;
    drain();
    checks++;
    if (btb - btb0 != 1) begin
      errors++;
      $display("FAIL overrun_back_to_back got=%0d required=1", btb - btb0);
    end
    checks++;
    if (frame_count !== fc0 + 16'd2) begin
      errors++;
      $display("FAIL overrun_frame_count got=%0d required=%0d", frame_count, fc0 + 16'd2);
    end
  endtask

  task automatic test_reset_midframe();
    int b0;
    bit hit;
    b0 = beats;
    hit = 1'b0;
    sink_ready = 1'b1;
    for (int k = 0; k < FL; k++) push(DW'(70 + k), DW'(90 + k), 1'b1);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (beats - b0 == 3) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midreset_wait got=%0d required=3", beats - b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if (sink_valid !== 1'b0 || sink_eop !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags got=%b%b%b required=000", sink_valid, sink_eop, overrun);
    end
    checks++;
    if (frame_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_counts got=%0d/%0d required=0/0", frame_count, drop_count);
    end
    for (int k = 0; k < FL; k++) push(DW'(k * 3), DW'(k * 5), 1'b1);
    drain();
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL midreset_frame_count got=%0d required=1", frame_count);
    end
  endtask

  task automatic test_dc();
    logic [15:0] fc0;
    fc0 = frame_count;
    sink_ready = 1'b1;
`ifdef SEQ_DCBLOCK_EN
    for (int k = 0; k < 4096; k++) push(DW'(1000), DW'(1000), 1'b1);
    drain();
    checks++;
    if ($signed(last_real) > 2 || $signed(last_real) < -2) begin
      errors++;
      $display("FAIL dc_converge got=%0d required=|y|<=2", $signed(last_real));
    end
    checks++;
    if (frame_count !== fc0 + 16'd512) begin
      errors++;
      $display("FAIL dc_frame_count got=%0d required=%0d", frame_count, fc0 + 16'd512);
    end
`else
    for (int k = 0; k < FL; k++) push(DW'(1000), DW'(1000), 1'b1);
    drain();
    checks++;
    if (last_real !== DW'(1000)) begin
      errors++;
      $display("FAIL dc_passthrough got=%0d required=1000", last_real);
    end
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL dc_frame_count got=%0d required=%0d", frame_count, fc0 + 16'd1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_enable();
    test_backpressure();
    test_overrun();
    test_reset_midframe();
    test_dc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout required=completion");
    $fatal(1, "watchdog");
  end

endmodule
